// File: rtl/sae.sv
// Simple asymmetric encryption engine: modular key generation, encryption and
// decryption of one byte per transaction, two-stage (capture, result) pipeline.
module sae #(
  parameter int N = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] data_input,
  input  logic [7:0] key_input,
  input  logic       inputs_valid,
  output logic [7:0] data_output,
  output logic       output_ready,
  output logic       err_invalid_ptxt_char,
  output logic       err_invalid_seckey,
  output logic       err_invalid_ctxt_char
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_KEYGEN = 2'b01,
    MODE_ENC    = 2'b10,
    MODE_DEC    = 2'b11
  } mode_e;

  localparam logic [7:0] N8 = 8'(N);
  localparam logic [8:0] N9 = 9'(N);

  logic       pending;
  mode_e      mode_q;
  logic [7:0] data_q;
  logic [7:0] key_q;

  logic       key_ok;
  logic       ptxt_ok;
  logic       ctxt_ok;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] mod_sum;
  logic [7:0] pub_key;

  // Capture stage: mode 00 is treated as "nothing to do" even when qualified.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pending <= 1'b0;
      mode_q  <= MODE_IDLE;
      data_q  <= '0;
      key_q   <= '0;
    end else begin
      pending <= inputs_valid && (mode != MODE_IDLE);
      if (inputs_valid && (mode != MODE_IDLE)) begin
        mode_q <= mode_e'(mode);
        data_q <= data_input;
        key_q  <= key_input;
      end
    end
  end

  assign key_ok  = (key_q != 8'd0) && (key_q < N8);
  assign ptxt_ok = (data_q >= 8'h20) && (data_q <= 8'h7E);
  assign ctxt_ok = (data_q <= 8'h7E);

  // Both operands are below 256 and the sum is at most 252 for valid inputs,
  // so one conditional subtraction brings it back into 0..N-1.
  assign sum9    = {1'b0, data_q} + {1'b0, key_q};
  assign diff9   = sum9 - N9;
  assign mod_sum = (sum9 >= N9) ? diff9[7:0] : sum9[7:0];
  assign pub_key = N8 - key_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_output           <= '0;
      output_ready          <= 1'b0;
      err_invalid_ptxt_char <= 1'b0;
      err_invalid_seckey    <= 1'b0;
      err_invalid_ctxt_char <= 1'b0;
    end else begin
      data_output           <= '0;
      output_ready          <= 1'b0;
      err_invalid_ptxt_char <= 1'b0;
      err_invalid_seckey    <= 1'b0;
      err_invalid_ctxt_char <= 1'b0;
      if (pending) begin
        case (mode_q)
          MODE_KEYGEN: begin
            if (key_ok) begin
              output_ready <= 1'b1;
              data_output  <= pub_key;
            end else begin
              err_invalid_seckey <= 1'b1;
            end
          end
          MODE_ENC: begin
            err_invalid_seckey    <= !key_ok;
            err_invalid_ptxt_char <= !ptxt_ok;
            if (key_ok && ptxt_ok) begin
              output_ready <= 1'b1;
              data_output  <= mod_sum;
            end
          end
          MODE_DEC: begin
            err_invalid_seckey    <= !key_ok;
            err_invalid_ctxt_char <= !ctxt_ok;
            if (key_ok && ctxt_ok) begin
              output_ready <= 1'b1;
              data_output  <= mod_sum;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sae.sv
// Self-checking bench for sae: directed steps, expected results queued when
// driven and compared one edge after capture.
module tb_sae;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] data_input;
  logic [7:0] key_input;
  logic       inputs_valid;
  logic [7:0] data_output;
  logic       output_ready;
  logic       err_invalid_ptxt_char;
  logic       err_invalid_seckey;
  logic       err_invalid_ctxt_char;

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       ep;
    logic       ek;
    logic       ec;
    string      tag;
  } exp_t;

  exp_t       scoreboard[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] lastData;
  logic [7:0] cipher[$];
  string      msg = "Hello, SAE! ~ 0x20";

  sae dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mode                  (mode),
    .data_input            (data_input),
    .key_input             (key_input),
    .inputs_valid          (inputs_valid),
    .data_output           (data_output),
    .output_ready          (output_ready),
    .err_invalid_ptxt_char (err_invalid_ptxt_char),
    .err_invalid_seckey    (err_invalid_seckey),
    .err_invalid_ctxt_char (err_invalid_ctxt_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written directly from the modular-arithmetic rules.
  function automatic exp_t model(input logic v, input logic [1:0] m,
                                 input logic [7:0] d, input logic [7:0] k,
                                 input string tag);
    exp_t e;
    bit   keyBad;
    e = '{data: 8'd0, rdy: 1'b0, ep: 1'b0, ek: 1'b0, ec: 1'b0, tag: tag};
    if (!v || m == 2'b00) return e;
    keyBad = (k == 8'd0) || (k > 8'd126);
    e.ek = keyBad;
    if (m == 2'b01) begin
      if (!keyBad) begin
        e.rdy  = 1'b1;
        e.data = 8'(127 - int'(k));
      end
    end else begin
      if (m == 2'b10) e.ep = (d < 8'h20) || (d > 8'h7E);
      else            e.ec = (d > 8'h7E);
      if (!keyBad && !e.ep && !e.ec) begin
        e.rdy  = 1'b1;
        e.data = 8'((int'(d) + int'(k)) % 127);
      end
    end
    return e;
  endfunction

  task automatic compareField(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAgainst(input exp_t e);
    compareField({e.tag, ".data"}, data_output, e.data);
    compareField({e.tag, ".ready"}, {7'd0, output_ready}, {7'd0, e.rdy});
    compareField({e.tag, ".err_ptxt"}, {7'd0, err_invalid_ptxt_char}, {7'd0, e.ep});
    compareField({e.tag, ".err_key"}, {7'd0, err_invalid_seckey}, {7'd0, e.ek});
    compareField({e.tag, ".err_ctxt"}, {7'd0, err_invalid_ctxt_char}, {7'd0, e.ec});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = scoreboard.pop_front();
    lastData = data_output;
    checkAgainst(e);
  endtask

  // One cycle: drive inputs, queue their expectation, then check the result
  // of the transaction captured on the previous edge.
  task automatic applyStimulus(input logic v, input logic [1:0] m,
                               input logic [7:0] d, input logic [7:0] k,
                               input string tag);
    inputs_valid = v;
    mode         = m;
    data_input   = d;
    key_input    = k;
    scoreboard.push_back(model(v, m, d, k, tag));
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic primeIdle();
    scoreboard.delete();
    scoreboard.push_back(model(1'b0, 2'b00, 8'd0, 8'd0, "idle_prime"));
  endtask

  initial begin
    exp_t zero;
    zero = model(1'b0, 2'b00, 8'd0, 8'd0, "reset");
    rst_n        = 1'b1;
    inputs_valid = 1'b0;
    mode         = 2'b00;
    data_input   = 8'd0;
    key_input    = 8'd0;
    #12;
    checkAgainst(zero);
    @(negedge clk);
    rst_n = 1'b0;
    primeIdle();

    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "idle0");
    applyStimulus(1'b1, 2'b01, 8'd0, 8'd20, "keygen20");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "keygen20_done");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "pulse_gone");

    applyStimulus(1'b1, 2'b10, 8'h41, 8'd107, "enc_A");
    applyStimulus(1'b1, 2'b10, 8'h7E, 8'd107, "enc_7E");
    applyStimulus(1'b1, 2'b10, 8'h20, 8'd107, "enc_20");
    applyStimulus(1'b1, 2'b11, 8'd45, 8'd20, "dec_45");
    applyStimulus(1'b1, 2'b11, 8'h00, 8'd20, "dec_00");
    applyStimulus(1'b1, 2'b01, 8'd0, 8'd126, "keygen126");
    applyStimulus(1'b1, 2'b01, 8'd0, 8'd1, "keygen1");

    applyStimulus(1'b1, 2'b01, 8'd0, 8'd0, "key0_gen");
    applyStimulus(1'b1, 2'b10, 8'h41, 8'd127, "key127_enc");
    applyStimulus(1'b1, 2'b11, 8'd10, 8'd200, "key200_dec");
    applyStimulus(1'b1, 2'b10, 8'h1F, 8'd107, "ptxt_1F");
    applyStimulus(1'b1, 2'b10, 8'h7F, 8'd107, "ptxt_7F");
    applyStimulus(1'b1, 2'b10, 8'h7F, 8'd0, "ptxt_and_key");
    applyStimulus(1'b1, 2'b11, 8'h80, 8'd20, "ctxt_80");
    applyStimulus(1'b1, 2'b11, 8'h7F, 8'd20, "ctxt_7F");
    applyStimulus(1'b1, 2'b11, 8'hFF, 8'd127, "ctxt_and_key");

    applyStimulus(1'b1, 2'b00, 8'h41, 8'd20, "mode00_valid");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "mode00_c1");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "mode00_c2");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "mode00_c3");

    // Inputs change right after capture; the queued result must not follow.
    applyStimulus(1'b1, 2'b10, 8'h41, 8'd107, "hold_capture");
    applyStimulus(1'b0, 2'b11, 8'h80, 8'd0, "hold_after");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "hold_idle");

    for (int i = 0; i < msg.len(); i++) begin
      applyStimulus(1'b1, 2'b10, msg[i], 8'd107, $sformatf("str_enc%0d", i));
      if (i > 0) cipher.push_back(lastData);
    end
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "str_enc_tail");
    cipher.push_back(lastData);
    // Decrypt expectations are the original characters, not the model.
    scoreboard.delete();
    scoreboard.push_back(model(1'b0, 2'b00, 8'd0, 8'd0, "str_gap"));
    for (int i = 0; i < msg.len(); i++) begin
      exp_t e;
      inputs_valid = 1'b1;
      mode         = 2'b11;
      data_input   = cipher[i];
      key_input    = 8'd20;
      e = '{data: msg[i], rdy: 1'b1, ep: 1'b0, ek: 1'b0, ec: 1'b0,
            tag: $sformatf("str_dec%0d", i)};
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
    end
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "str_dec_tail");

    // Reset between capture and result discards the transaction.
    inputs_valid = 1'b1;
    mode         = 2'b01;
    data_input   = 8'd0;
    key_input    = 8'd20;
    @(posedge clk);
    #1;
    inputs_valid = 1'b0;
    mode         = 2'b00;
    rst_n        = 1'b1;
    #1;
    zero.tag = "reset_mid";
    checkAgainst(zero);
    @(posedge clk);
    #1;
    zero.tag = "reset_held";
    checkAgainst(zero);
    rst_n = 1'b0;
    primeIdle();
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "after_reset1");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "after_reset2");
    applyStimulus(1'b1, 2'b10, 8'h41, 8'd107, "after_reset_enc");
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, "after_reset_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
